mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute ALU. It consumes the ALU result (`res_R`) as the effective address for RV32I loads/stores, flw/fsw and the RV32S matrix load/store. It drives a single-outstanding 32-bit memory bus, and hands data plus the write-back result to the write-back stage through a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode/funct3 encodings, FSM state type and access-size helpers
// for the memory-access stage.
package mem_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_MLOAD  = 7'b0001011;
    localparam logic [6:0] OP_MSTORE = 7'b0101011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Unsigned variants do not exist for stores; they fall back to word like any undefined code.
    function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B:    access_size = SZ_B;
            F3_H:    access_size = SZ_H;
            F3_BU:   access_size = is_store ? SZ_W : SZ_B;
            F3_HU:   access_size = is_store ? SZ_W : SZ_H;
            default: access_size = SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and store
// data replication with matching byte strobes.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = rdata;
        wdata     = store_data;
        wstrb     = '1;
        case (size)
            SZ_B: begin
                load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << addr_lo;
            end
            default: begin
                load_data = rdata;
                wdata     = store_data;
                wstrb     = '1;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding 32-bit bus master for scalar,
// float and matrix loads/stores, with pass-through for non-memory ops.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAT_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [4:0]                rd,
    input  logic [31:0]               addr_res,
    input  logic [31:0]               src2R,
    input  logic [31:0]               src2F,
    input  logic [32*MAT_WORDS-1:0]   src2M,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic                      mem_ack,
    input  logic [31:0]               mem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_rd,
    output logic [31:0]               res_R,
    output logic [31:0]               res_F,
    output logic [32*MAT_WORDS-1:0]   res_M,
    output logic                      err_misalign
);

    localparam int unsigned BW = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;

    state_t state, state_nx;

    logic [6:0]               op_q;
    logic [2:0]               f3_q;
    logic [31:0]              addr_q;
    logic [31:0]              s2r_q;
    logic [31:0]              s2f_q;
    logic [32*MAT_WORDS-1:0]  s2m_q;
    logic [BW-1:0]            beat;

    logic   scalar_in, is_mem_in, mis_in;
    size_t  size_in, size_q;
    logic   is_matrix_q, is_store_q;
    logic [BW-1:0] last_beat;
    logic   accept, ack_ok;

    logic [31:0] lane_load, lane_wdata;
    logic [3:0]  lane_wstrb;

    assign scalar_in = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_mem_in = scalar_in || (opcode == OP_FLW) || (opcode == OP_FSW) ||
                       (opcode == OP_MLOAD) || (opcode == OP_MSTORE);
    assign size_in   = scalar_in ? access_size(funct3, opcode == OP_STORE) : SZ_W;
    assign mis_in    = misaligned(size_in, addr_res[1:0]);

    assign is_matrix_q = (op_q == OP_MLOAD) || (op_q == OP_MSTORE);
    assign is_store_q  = (op_q == OP_STORE) || (op_q == OP_FSW) || (op_q == OP_MSTORE);
    assign size_q      = ((op_q == OP_LOAD) || (op_q == OP_STORE)) ?
                         access_size(f3_q, op_q == OP_STORE) : SZ_W;
    assign last_beat   = is_matrix_q ? BW'(MAT_WORDS - 1) : '0;

    assign accept = (state == IDLE) && in_valid;
    assign ack_ok = (state == REQ) && mem_ack;

    mem_lane_align u_align (
        .size       (size_q),
        .sign_ext   (~f3_q[2]),
        .addr_lo    (addr_q[1:0]),
        .rdata      (mem_rdata),
        .store_data ((op_q == OP_FSW) ? s2f_q : s2r_q),
        .load_data  (lane_load),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid)
                    state_nx = (!is_mem_in || mis_in) ? DONE : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack && (beat == last_beat))
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs are forced to zero outside REQ so nothing leaks while idle or in reset.
    always_comb begin
        mem_we    = mem_req & is_store_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (mem_req)
            mem_addr = {addr_q[31:2], 2'b00} + (32'(beat) << 2);
        if (mem_we) begin
            if (is_matrix_q) begin
                mem_wdata = s2m_q[32*beat +: 32];
                mem_wstrb = '1;
            end else begin
                mem_wdata = lane_wdata;
                mem_wstrb = lane_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            f3_q         <= '0;
            addr_q       <= '0;
            s2r_q        <= '0;
            s2f_q        <= '0;
            s2m_q        <= '0;
            beat         <= '0;
            out_rd       <= '0;
            res_R        <= '0;
            res_F        <= '0;
            res_M        <= '0;
            err_misalign <= 1'b0;
        end else if (accept) begin
            op_q         <= opcode;
            f3_q         <= funct3;
            addr_q       <= addr_res;
            s2r_q        <= src2R;
            s2f_q        <= src2F;
            s2m_q        <= src2M;
            beat         <= '0;
            out_rd       <= rd;
            res_R        <= is_mem_in ? '0 : addr_res;
            res_F        <= '0;
            res_M        <= '0;
            err_misalign <= is_mem_in & mis_in;
        end else if (ack_ok) begin
            beat <= beat + BW'(1);
            case (op_q)
                OP_LOAD:  res_R <= lane_load;
                OP_FLW:   res_F <= mem_rdata;
                OP_MLOAD: res_M[32*beat +: 32] <= mem_rdata;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: scalar/float/matrix accesses,
// misalignment, pass-through, reset mid-transfer and write-back backpressure.
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_MLOAD  = 7'b0001011;
    localparam logic [6:0] OP_MSTORE = 7'b0101011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [4:0]   rd;
    logic [31:0]  addr_res;
    logic [31:0]  src2R;
    logic [31:0]  src2F;
    logic [511:0] src2M;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_rd;
    logic [31:0]  res_R;
    logic [31:0]  res_F;
    logic [511:0] res_M;
    logic         err_misalign;

    int checks = 0;
    int failures = 0;

    logic [31:0] rec_addr  [16];
    logic [31:0] rec_wdata [16];
    logic [3:0]  rec_wstrb [16];
    logic        rec_we    [16];
    bit          timed_out;

    always #5 clk = ~clk;

    mem_stage #(.MAT_WORDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .rd           (rd),
        .addr_res     (addr_res),
        .src2R        (src2R),
        .src2F        (src2F),
        .src2M        (src2M),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .res_R        (res_R),
        .res_F        (res_F),
        .res_M        (res_M),
        .err_misalign (err_misalign)
    );

    // Present one instruction for a single cycle; caller is at a negedge with the DUT idle.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] s2r, input logic [31:0] s2f,
                         input logic [511:0] s2m);
        opcode = op; funct3 = f3; rd = r; addr_res = a;
        src2R = s2r; src2F = s2f; src2M = s2m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bus responder: ack nbeats requests after `delay` idle cycles each, recording the bus.
    task automatic serve(input int nbeats, input int delay, input logic [31:0] rval,
                         input bit idx_data);
        timed_out = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < 50 && !mem_req; w++) @(negedge clk);
            if (!mem_req) begin
                timed_out = 1'b1;
                return;
            end
            for (int d = 0; d < delay; d++) @(negedge clk);
            rec_addr[b]  = mem_addr;
            rec_wdata[b] = mem_wdata;
            rec_wstrb[b] = mem_wstrb;
            rec_we[b]    = mem_we;
            mem_rdata = idx_data ? 32'(b) : rval;
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_bus got req=%0b we=%0b exp=0/0", mem_req, mem_we); end
        checks++; if (out_valid !== 1'b0 || err_misalign !== 1'b0) begin failures++; $display("FAIL reset_out got ov=%0b err=%0b exp=0/0", out_valid, err_misalign); end
        checks++; if (res_R !== 32'h0 || res_F !== 32'h0 || res_M !== '0 || mem_addr !== 32'h0) begin failures++; $display("FAIL reset_data got res_R=%h res_F=%h addr=%h exp=0", res_R, res_F, mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_lw();
        issue(OP_LOAD, 3'b010, 5'd4, 32'h100, 32'h0, 32'h0, '0);
        checks++; if (mem_req !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL lw_req got req=%0b rdy=%0b exp=1/0", mem_req, in_ready); end
        serve(1, 3, 32'hDEADBEEF, 1'b0);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL lw_timeout got=1 exp=0"); end
        checks++; if (rec_addr[0] !== 32'h100 || rec_we[0] !== 1'b0) begin failures++; $display("FAIL lw_addr got addr=%h we=%0b exp=00000100/0", rec_addr[0], rec_we[0]); end
        checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL lw_latency got ov=%0b req=%0b exp=1/0", out_valid, mem_req); end
        checks++; if (res_R !== 32'hDEADBEEF || out_rd !== 5'd4 || err_misalign !== 1'b0) begin failures++; $display("FAIL lw_result got res_R=%h rd=%0d err=%0b exp=deadbeef/4/0", res_R, out_rd, err_misalign); end
        @(negedge clk);
    endtask

    task automatic test_sub_word_loads();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
        for (int i = 0; i < 4; i++) begin
            issue(OP_LOAD, f3s[i], 5'd5, ads[i], 32'h0, 32'h0, '0);
            serve(1, 0, 32'h80112233, 1'b0);
            checks++; if (timed_out !== 1'b0 || rec_addr[0] !== 32'h100) begin failures++; $display("FAIL subload_addr[%0d] got=%h to=%0b exp=00000100", i, rec_addr[0], timed_out); end
            checks++; if (out_valid !== 1'b1 || res_R !== exps[i]) begin failures++; $display("FAIL subload_data[%0d] got=%h ov=%0b exp=%h", i, res_R, out_valid, exps[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_stores();
        logic [6:0]  ops [4] = '{OP_STORE, OP_STORE, OP_STORE, OP_FSW};
        logic [2:0]  f3s [4] = '{3'b001, 3'b000, 3'b010, 3'b010};
        logic [31:0] ads [4] = '{32'h102, 32'h101, 32'h200, 32'h204};
        logic [31:0] eadr[4] = '{32'h100, 32'h100, 32'h200, 32'h204};
        logic [31:0] ewd [4] = '{32'h12341234, 32'hABABABAB, 32'hCAFEF00D, 32'h3F800000};
        logic [3:0]  est [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
        logic [31:0] s2rs[4] = '{32'h00001234, 32'h000000AB, 32'hCAFEF00D, 32'h11111111};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], f3s[i], 5'd0, ads[i], s2rs[i], 32'h3F800000, '0);
            serve(1, 1, 32'h0, 1'b0);
            checks++; if (timed_out !== 1'b0 || rec_addr[0] !== eadr[i] || rec_we[0] !== 1'b1) begin failures++; $display("FAIL store_addr[%0d] got=%h we=%0b exp=%h/1", i, rec_addr[0], rec_we[0], eadr[i]); end
            checks++; if (rec_wdata[0] !== ewd[i] || rec_wstrb[0] !== est[i]) begin failures++; $display("FAIL store_data[%0d] got=%h/%b exp=%h/%b", i, rec_wdata[0], rec_wstrb[0], ewd[i], est[i]); end
            checks++; if (out_valid !== 1'b1 || err_misalign !== 1'b0) begin failures++; $display("FAIL store_done[%0d] got ov=%0b err=%0b exp=1/0", i, out_valid, err_misalign); end
            @(negedge clk);
        end
        issue(OP_FLW, 3'b010, 5'd7, 32'h300, 32'h0, 32'h0, '0);
        serve(1, 0, 32'h40490FDB, 1'b0);
        checks++; if (res_F !== 32'h40490FDB || res_R !== 32'h0 || out_valid !== 1'b1) begin failures++; $display("FAIL flw got res_F=%h res_R=%h exp=40490fdb/0", res_F, res_R); end
        @(negedge clk);
    endtask

    task automatic test_matrix_load();
        logic [511:0] exp_m;
        int bad;
        for (int i = 0; i < 16; i++) exp_m[32*i +: 32] = 32'(i);
        issue(OP_MLOAD, 3'b010, 5'd2, 32'h2000, 32'h0, 32'h0, '0);
        serve(16, 0, 32'h0, 1'b1);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL mload_timeout got=1 exp=0"); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rec_addr[i] !== 32'h2000 + 32'(4*i)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL mload_addrs got %0d wrong, first=%h last=%h exp=00002000..0000203c", bad, rec_addr[0], rec_addr[15]); end
        checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL mload_done got ov=%0b req=%0b exp=1/0", out_valid, mem_req); end
        checks++; if (res_M[31:0] !== 32'd0 || res_M[511:480] !== 32'd15) begin failures++; $display("FAIL mload_ends got lo=%h hi=%h exp=0/f", res_M[31:0], res_M[511:480]); end
        checks++; if (res_M !== exp_m) begin failures++; $display("FAIL mload_all got=%h exp=%h", res_M, exp_m); end
        @(negedge clk);
    endtask

    task automatic test_matrix_store_wrap();
        logic [511:0] m;
        int bad_a, bad_d;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = 32'hA5000000 | 32'(i);
        issue(OP_MSTORE, 3'b010, 5'd0, 32'hFFFFFFF8, 32'h0, 32'h0, m);
        serve(16, 0, 32'h0, 1'b0);
        checks++; if (timed_out !== 1'b0 || out_valid !== 1'b1 || err_misalign !== 1'b0) begin failures++; $display("FAIL mstore_done got to=%0b ov=%0b err=%0b exp=0/1/0", timed_out, out_valid, err_misalign); end
        checks++; if (rec_addr[0] !== 32'hFFFFFFF8 || rec_addr[1] !== 32'hFFFFFFFC || rec_addr[2] !== 32'h0 || rec_addr[15] !== 32'h34) begin failures++; $display("FAIL mstore_wrap got %h %h %h %h exp=fffffff8 fffffffc 0 34", rec_addr[0], rec_addr[1], rec_addr[2], rec_addr[15]); end
        bad_a = 0; bad_d = 0;
        for (int i = 0; i < 16; i++) begin
            if (rec_wdata[i] !== (32'hA5000000 | 32'(i))) bad_d++;
            if (rec_wstrb[i] !== 4'b1111 || rec_we[i] !== 1'b1) bad_a++;
        end
        checks++; if (bad_d != 0) begin failures++; $display("FAIL mstore_wdata got %0d wrong words, w0=%h exp=a5000000", bad_d, rec_wdata[0]); end
        checks++; if (bad_a != 0) begin failures++; $display("FAIL mstore_strb got %0d wrong beats, s0=%b exp=1111", bad_a, rec_wstrb[0]); end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        logic [6:0]  ops [3] = '{OP_LOAD, OP_STORE, OP_FLW};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b010};
        logic [31:0] ads [3] = '{32'h101, 32'h103, 32'h102};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], f3s[i], 5'd6, ads[i], 32'h0, 32'h0, '0);
            checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || err_misalign !== 1'b1) begin failures++; $display("FAIL misalign[%0d] got req=%0b ov=%0b err=%0b exp=0/1/1", i, mem_req, out_valid, err_misalign); end
            @(negedge clk);
        end
        issue(OP_STORE, 3'b000, 5'd0, 32'h103, 32'h0000005A, 32'h0, '0);
        serve(1, 0, 32'h0, 1'b0);
        checks++; if (timed_out !== 1'b0 || err_misalign !== 1'b0 || rec_wstrb[0] !== 4'b1000) begin failures++; $display("FAIL sb_odd got to=%0b err=%0b strb=%b exp=0/0/1000", timed_out, err_misalign, rec_wstrb[0]); end
        @(negedge clk);
        issue(OP_ADDI, 3'b000, 5'd8, 32'h7, 32'h0, 32'h0, '0);
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || err_misalign !== 1'b0) begin failures++; $display("FAIL addi_flags got req=%0b ov=%0b err=%0b exp=0/1/0", mem_req, out_valid, err_misalign); end
        checks++; if (res_R !== 32'h7 || out_rd !== 5'd8 || res_F !== 32'h0 || res_M !== '0) begin failures++; $display("FAIL addi_data got res_R=%h rd=%0d exp=7/8", res_R, out_rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        issue(OP_MSTORE, 3'b010, 5'd0, 32'h3000, 32'h0, 32'h0, {16{32'h0F0F0F0F}});
        serve(5, 0, 32'h0, 1'b0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3014) begin failures++; $display("FAIL beat5_bus got req=%0b addr=%h exp=1/00003014", mem_req, mem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset_bus got req=%0b we=%0b ov=%0b exp=0/0/0", mem_req, mem_we, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL midreset_idle got rdy=%0b req=%0b exp=1/0", in_ready, mem_req); end
    endtask

    task automatic test_back_to_back();
        issue(OP_LOAD, 3'b010, 5'd1, 32'h40, 32'h0, 32'h0, '0);
        for (int w = 0; w < 50 && !mem_req; w++) @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL b2b_req got=%0b exp=1", mem_req); end
        opcode = OP_ADDI; funct3 = 3'b000; rd = 5'd3; addr_res = 32'h99;
        in_valid = 1'b1;
        mem_rdata = 32'h11; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || res_R !== 32'h11 || out_rd !== 5'd1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold got ov=%0b res_R=%h rd=%0d rdy=%0b exp=1/11/1/0", out_valid, res_R, out_rd, in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got rdy=%0b ov=%0b exp=1/0", in_ready, out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || res_R !== 32'h99 || out_rd !== 5'd3) begin failures++; $display("FAIL b2b_second got ov=%0b res_R=%h rd=%0d exp=1/99/3", out_valid, res_R, out_rd); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready = 1'b0;
        issue(OP_ADDI, 3'b000, 5'd9, 32'h55, 32'h0, 32'h0, '0);
        opcode = OP_ADDI; rd = 5'd12; addr_res = 32'hBAD;
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || res_R !== 32'h55 || out_rd !== 5'd9 || in_ready !== 1'b0 || mem_req !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL backpressure got %0d unstable cycles, res_R=%h rd=%0d exp=0 (55/9)", bad, res_R, out_rd); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL backpressure_release got ov=%0b rdy=%0b exp=0/1", out_valid, in_ready); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; rd = '0;
        addr_res = '0; src2R = '0; src2F = '0; src2M = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_matrix_load();
        test_matrix_store_wrap();
        test_misalign();
        test_reset_mid_transfer();
        test_back_to_back();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
